// File: rtl/march_bist_ctrl.sv
// march_bist_ctrl: March C- BIST sequencer for one embedded RAM.
//   Steps an external address generator and issues read/write strobes through the
//   six March C- elements. Each read is checked against its background one cycle later.
//   Ports: clk, rst_n (async, active-low), start (pulse, accepted in IDLE/DONE),
//     adr_in (generator address),
//     gen_rst/gen_preset/gen_en/gen_up (generator controls),
//     mem_we/mem_re/mem_wdata/mem_rdata (RAM side),
//     busy/done/fail/fail_adr/fail_elem (status).
//   Optional: define BIST_FAIL_STOP_EN to abort the test on the first mismatch.
module march_bist_ctrl #(
    parameter int Adr_size  = 8,
    parameter int Data_size = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [Adr_size-1:0]  adr_in,
    output logic                 gen_rst,
    output logic                 gen_preset,
    output logic                 gen_en,
    output logic                 gen_up,
    output logic                 mem_we,
    output logic                 mem_re,
    output logic [Data_size-1:0] mem_wdata,
    input  logic [Data_size-1:0] mem_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [Adr_size-1:0]  fail_adr,
    output logic [2:0]           fail_elem
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] RD    = 3'd2;
    localparam logic [2:0] WR    = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
`ifdef BIST_FAIL_STOP_EN
    localparam logic STOP_EN = 1'b1;
`else
    localparam logic STOP_EN = 1'b0;
`endif

    logic [2:0]           state_q, state_d, elem_q, elem_d, fail_elem_q, fail_elem_d;
    logic [Data_size-1:0] exp_q, exp_d;
    logic [Adr_size-1:0]  cmp_adr_q, cmp_adr_d, fail_adr_q, fail_adr_d;
    logic                 cmp_vld_q, cmp_vld_d, fail_q, fail_d;
    logic                 up, has_rd, has_wr, rd_one, wr_one, last, mismatch, abort;

    // Element decode: M3/M4 run downwards, M0 has no read, M5 has no write.
    assign up       = !(elem_q == 3'd3 || elem_q == 3'd4);
    assign has_rd   = elem_q != 3'd0;
    assign has_wr   = elem_q != 3'd5;
    assign rd_one   = elem_q == 3'd2 || elem_q == 3'd4;
    assign wr_one   = elem_q == 3'd1 || elem_q == 3'd3;
    assign last     = up ? (&adr_in) : ~|adr_in;
    assign mismatch = cmp_vld_q && (mem_rdata != exp_q);
    assign abort    = STOP_EN && mismatch;

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        fail_d      = fail_q;
        fail_adr_d  = fail_adr_q;
        fail_elem_d = fail_elem_q;
        gen_en      = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = SETUP;
                    elem_d      = 3'd0;
                    fail_d      = 1'b0;
                    fail_adr_d  = '0;
                    fail_elem_d = 3'd0;
                end
            end
            SETUP: state_d = has_rd ? RD : WR;
            RD: begin
                mem_re = 1'b1;
                if (has_wr) begin
                    state_d = WR;
                end else begin
                    // M5 is read-only, so the read is also the final op of the address.
                    gen_en  = !last;
                    state_d = last ? DRAIN : RD;
                end
            end
            WR: begin
                mem_we = 1'b1;
                gen_en = !last;
                if (last) begin
                    state_d = SETUP;
                    elem_d  = elem_q + 3'd1;
                end else begin
                    state_d = has_rd ? RD : WR;
                end
            end
            DRAIN: state_d = DONE;
            default: state_d = IDLE;
        endcase
        // Only the first mismatch of a run is recorded.
        if (mismatch && !fail_q) begin
            fail_d      = 1'b1;
            fail_adr_d  = cmp_adr_q;
            fail_elem_d = elem_q;
        end
        if (abort) begin
            state_d = DONE;
            mem_re  = 1'b0;
            mem_we  = 1'b0;
            gen_en  = 1'b0;
        end
        // Read data returns next cycle; remember what and where it should be.
        cmp_vld_d = mem_re;
        exp_d     = {Data_size{rd_one}};
        cmp_adr_d = adr_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            elem_q      <= 3'd0;
            exp_q       <= '0;
            cmp_adr_q   <= '0;
            cmp_vld_q   <= 1'b0;
            fail_q      <= 1'b0;
            fail_adr_q  <= '0;
            fail_elem_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            exp_q       <= exp_d;
            cmp_adr_q   <= cmp_adr_d;
            cmp_vld_q   <= cmp_vld_d;
            fail_q      <= fail_d;
            fail_adr_q  <= fail_adr_d;
            fail_elem_q <= fail_elem_d;
        end
    end

    assign gen_rst    = state_q == SETUP && up;
    assign gen_preset = state_q == SETUP && !up;
    assign gen_up     = (state_q == SETUP || state_q == RD || state_q == WR) && up;
    assign mem_wdata  = mem_we ? {Data_size{wr_one}} : '0;
    assign busy       = state_q == SETUP || state_q == RD || state_q == WR || state_q == DRAIN;
    assign done       = state_q == DONE;
    assign fail       = fail_q;
    assign fail_adr   = fail_adr_q;
    assign fail_elem  = fail_elem_q;
endmodule

// File: tb/tb_march_bist_ctrl.sv
// tb_march_bist_ctrl: self-checking bench for march_bist_ctrl with generator and faulty RAM models.
module tb_march_bist_ctrl;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int N  = 8;
`ifdef BIST_FAIL_STOP_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [AW-1:0] adr_in;
    logic          gen_rst, gen_preset, gen_en, gen_up, mem_we, mem_re, busy, done, fail;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [AW-1:0] fail_adr;
    logic [2:0]    fail_elem;

    int nerr = 0, nchk = 0;

    always #5 clk = ~clk;

    march_bist_ctrl #(.Adr_size(AW), .Data_size(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .adr_in(adr_in),
        .gen_rst(gen_rst), .gen_preset(gen_preset), .gen_en(gen_en), .gen_up(gen_up),
        .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .fail(fail), .fail_adr(fail_adr), .fail_elem(fail_elem)
    );

    // Address generator: sync clear, preset, up/down step.
    logic [AW-1:0] gadr = '0;
    assign adr_in = gadr;
    always @(posedge clk) begin
        if (gen_rst) gadr <= '0;
        else if (gen_preset) gadr <= '1;
        else if (gen_en) gadr <= gen_up ? gadr + 1'b1 : gadr - 1'b1;
    end

    // RAM with one optional stuck-at bit seen on reads; registered read port.
    bit fen = 1'b0, fval = 1'b0;
    int fadr = 0, fbit = 0;
    logic [DW-1:0] ram [N];
    logic [DW-1:0] rdata_q = '0;
    assign mem_rdata = rdata_q;

    function automatic logic [DW-1:0] rd_fault(input int a, input logic [DW-1:0] v);
        logic [DW-1:0] r;
        r = v;
        if (fen && a == fadr) r[fbit] = fval;
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_we) ram[adr_in] <= mem_wdata;
        if (mem_re) rdata_q <= rd_fault(int'(adr_in), ram[adr_in]);
    end

    // Reference: per-cycle schedule of March C- derived from the element list.
    typedef struct {
        int kind;
        bit up, re, we, en;
        int adr;
        logic [DW-1:0] wd;
    } cyc_t;
    cyc_t sched[$];
    bit m_found;
    int m_idx, m_elem, m_adr;

    task automatic build_model();
        int rdv[6] = '{-1, 0, 1, 0, 1, 0};
        int wrv[6] = '{0, 1, 0, 1, 0, -1};
        bit upv[6] = '{1, 1, 1, 0, 0, 1};
        logic [DW-1:0] mm [N];
        logic [DW-1:0] v;
        logic b;
        cyc_t x;
        sched.delete();
        m_found = 1'b0;
        m_idx = 0; m_elem = 0; m_adr = 0;
        for (int a = 0; a < N; a++) mm[a] = '0;
        for (int el = 0; el < 6; el++) begin
            x = '{kind: 0, up: upv[el], re: 0, we: 0, en: 0, adr: 0, wd: '0};
            sched.push_back(x);
            for (int k = 0; k < N; k++) begin
                int a;
                a = upv[el] ? k : N - 1 - k;
                if (rdv[el] >= 0) begin
                    b = rdv[el][0];
                    x = '{kind: 1, up: upv[el], re: 1, we: 0, en: (wrv[el] < 0 && k != N - 1), adr: a, wd: '0};
                    v = rd_fault(a, mm[a]);
                    if (!m_found && v !== {DW{b}}) begin
                        m_found = 1'b1; m_idx = sched.size(); m_elem = el; m_adr = a;
                    end
                    sched.push_back(x);
                end
                if (wrv[el] >= 0) begin
                    b = wrv[el][0];
                    x = '{kind: 2, up: upv[el], re: 0, we: 1, en: (k != N - 1), adr: a, wd: {DW{b}}};
                    mm[a] = {DW{b}};
                    sched.push_back(x);
                end
            end
        end
        x = '{kind: 3, up: 0, re: 0, we: 0, en: 0, adr: 0, wd: '0};
        sched.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_test(input string tag, input bit spur, output int done_c,
                            output int nre, output int nwe, output int npre, output int nrst);
        int exp_done, ere, ewe, bad;
        cyc_t x;
        logic [7:0] act, exv;
        build_model();
        exp_done = (STOP && m_found) ? m_idx + 2 : sched.size();
        ere = 0; ewe = 0;
        for (int c = 0; c < exp_done; c++)
            if (!(STOP && m_found && c > m_idx)) begin
                ere += int'(sched[c].re);
                ewe += int'(sched[c].we);
            end
        done_c = -1; nre = 0; nwe = 0; npre = 0; nrst = 0; bad = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (c < exp_done) begin
                x = sched[c];
                if (STOP && m_found && c > m_idx) begin x.re = 0; x.we = 0; x.en = 0; end
                act = {gen_rst, gen_preset, gen_en, mem_re, mem_we, busy, done, fail};
                exv = {x.kind == 0 && x.up, x.kind == 0 && !x.up, x.en, x.re, x.we, 1'b1, 1'b0,
                       m_found && c >= m_idx + 2};
                if (act !== exv || (x.kind < 3 && gen_up !== x.up) ||
                    ((x.re || x.we) && int'(adr_in) != x.adr) || (x.we && mem_wdata !== x.wd))
                    if (bad == 0) bad = c + 1;
            end
            if (int'(gen_rst) + int'(gen_preset) + int'(gen_en) > 1 && bad == 0) bad = c + 1;
            nre += int'(mem_re); nwe += int'(mem_we);
            npre += int'(gen_preset); nrst += int'(gen_rst);
            if (done) begin done_c = c; break; end
            start = (spur && c < exp_done) ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_seq_bad_cycle"}, 32'(bad), 0);
        check({tag, "_done_cycle"}, 32'(done_c), 32'(exp_done));
        check({tag, "_busy_in_done"}, 32'(busy), 0);
        check({tag, "_re_count"}, 32'(nre), 32'(ere));
        check({tag, "_we_count"}, 32'(nwe), 32'(ewe));
        check({tag, "_fail"}, 32'(fail), 32'(m_found));
        if (m_found) begin
            check({tag, "_fail_adr"}, 32'(fail_adr), 32'(m_adr));
            check({tag, "_fail_elem"}, 32'(fail_elem), 32'(m_elem));
        end
    endtask

    typedef struct {
        bit fen;
        int fadr, fbit;
        bit fval, efail;
        int eadr, eelem;
    } vec_t;
    vec_t tbl[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dc, nre, nwe, npre, nrst;
        logic [31:0] outs;
        tbl[0] = '{fen: 0, fadr: 0, fbit: 0, fval: 0, efail: 0, eadr: 0, eelem: 0};
        tbl[1] = '{fen: 1, fadr: 5, fbit: 0, fval: 1, efail: 1, eadr: 5, eelem: 1};
        tbl[2] = '{fen: 1, fadr: 3, fbit: 2, fval: 0, efail: 1, eadr: 3, eelem: 2};
        tbl[3] = '{fen: 1, fadr: 0, fbit: 7, fval: 1, efail: 1, eadr: 0, eelem: 1};
        tbl[4] = '{fen: 1, fadr: 7, fbit: 4, fval: 0, efail: 1, eadr: 7, eelem: 2};

        repeat (2) @(negedge clk);
        outs = 32'({gen_rst, gen_preset, gen_en, gen_up, mem_we, mem_re, busy, done, fail,
                    mem_wdata, fail_adr, fail_elem});
        check("reset_outputs", outs, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'({busy, done}), 0);

        // Clean pass: fixed latency and strobe counts.
        fen = 1'b0;
        run_test("clean", 1'b0, dc, nre, nwe, npre, nrst);
        check("clean_done_edge", 32'(dc), 87);
        check("clean_re_40", 32'(nre), 40);
        check("clean_we_40", 32'(nwe), 40);
        check("clean_preset_pulses", 32'(npre), 2);
        check("clean_rst_pulses", 32'(nrst), 4);

        // Fault table.
        for (int i = 0; i < 5; i++) begin
            fen = tbl[i].fen; fadr = tbl[i].fadr; fbit = tbl[i].fbit; fval = tbl[i].fval;
            run_test($sformatf("tbl%0d", i), 1'b0, dc, nre, nwe, npre, nrst);
            check($sformatf("tbl%0d_fail", i), 32'(fail), 32'(tbl[i].efail));
            if (tbl[i].efail) begin
                check($sformatf("tbl%0d_fail_adr", i), 32'(fail_adr), 32'(tbl[i].eadr));
                check($sformatf("tbl%0d_fail_elem", i), 32'(fail_elem), 32'(tbl[i].eelem));
            end
            if (i == 1) check("stuck5_done_edge", 32'(dc), STOP ? 22 : 87);
        end

        // Rerun from DONE after a failing pass must clear fail and pass cleanly.
        fen = 1'b0;
        run_test("rerun", 1'b0, dc, nre, nwe, npre, nrst);
        check("rerun_fail_cleared", 32'(fail), 0);

        // Asynchronous reset in the middle of M2 with fail already set.
        fen = 1'b1; fadr = 5; fbit = 0; fval = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        outs = 32'({gen_rst, gen_preset, gen_en, gen_up, mem_we, mem_re, busy, done, fail,
                    mem_wdata, fail_adr, fail_elem});
        check("async_reset_outputs", outs, 0);
        @(negedge clk) rst_n = 1'b1;
        fen = 1'b0;
        run_test("post_reset", 1'b0, dc, nre, nwe, npre, nrst);
        check("post_reset_done_edge", 32'(dc), 87);

        // Random faults with spurious start pulses while busy.
        for (int r = 0; r < 8; r++) begin
            fen = 1'($urandom_range(0, 1)); fadr = int'($urandom_range(0, N - 1));
            fbit = int'($urandom_range(0, DW - 1)); fval = 1'($urandom_range(0, 1));
            run_test($sformatf("rnd%0d", r), 1'b1, dc, nre, nwe, npre, nrst);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/march_bist_ctrl.md
Name: march_bist_ctrl

Overview:
- March C- BIST sequencer for one embedded RAM.
- Drives the control pins of the BIST address generator (sync reset-to-zero, preset-to-ones, enable, up/down) and sees its address on adr_in.
- Issues memory read/write strobes with background data and compares read data one cycle later.
- Reports busy/done/fail with the first failing address and element to the test access logic.

Parameters:
- Adr_size, 8, address width; memory depth N = 2^Adr_size.
- Data_size, 8, memory word width; background words are all-0 or all-1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; sampled only in IDLE or DONE.
- adr_in  input  Adr_size  current address from the address generator.
- gen_rst  output  1  generator synchronous clear to 0.
- gen_preset  output  1  generator synchronous preset to all-ones.
- gen_en  output  1  generator step enable.
- gen_up  output  1  generator direction; 1 = increment.
- mem_we  output  1  memory write strobe.
- mem_re  output  1  memory read strobe; data returns on mem_rdata next cycle.
- mem_wdata  output  Data_size  write background.
- mem_rdata  input  Data_size  read data.
- busy  output  1  test running.
- done  output  1  test finished; held until next start.
- fail  output  1  sticky mismatch flag.
- fail_adr  output  Adr_size  address of first mismatch.
- fail_elem  output  3  march element (0-5) of first mismatch.

Behaviour:
- Reset values: all outputs 0, state IDLE. An asserted rst_n aborts a running test immediately.
- March elements:
  - M0 up(w0)
  - M1 up(r0,w1)
  - M2 up(r1,w0)
  - M3 down(r0,w1)
  - M4 down(r1,w0)
  - M5 up(r0)
- States: IDLE, SETUP, RD, WR, DRAIN, DONE.
  - IDLE/DONE + start -> SETUP, elem=0; fail, fail_adr and fail_elem are cleared and done drops.
  - SETUP, 1 cycle: gen_rst=1 for up elements, gen_preset=1 for down elements; gen_up set to the element direction and held for the whole element. Next state: RD (M1-M5) or WR (M0).
  - RD: mem_re=1. Next state WR (M1-M4). For M5 it repeats RD per address.
  - WR: mem_we=1; mem_wdata = element write value replicated.
- Stepping:
  - In the final op cycle of each address, gen_en=1 unless adr_in is the last address (all-ones for up, zero for down).
  - On the last address: the next state is SETUP with elem+1. After M5 the next state is DRAIN.
  - gen_rst, gen_preset and gen_en are mutually exclusive.
- Compare pipeline:
  - On each RD cycle, register the expected value and adr_in.
  - Next cycle: mismatch = mem_rdata != expected. The first mismatch sets fail and captures fail_adr/fail_elem; later mismatches do not overwrite.
  - DRAIN (1 cycle) compares the final read, then goes to DONE.
- busy=1 in SETUP, RD, WR and DRAIN. done=1 only in DONE.
- start while busy: ignored.
- Latency: done rises 10N+7 rising edges after the edge that samples start (6 SETUP + 10N op cycles + DRAIN).

Optional Feature:
- BIST_FAIL_STOP_EN defined: the cycle a mismatch is detected, next state = DONE (abort). No further mem_we/mem_re/gen_en; fail information is captured as usual.
- Undefined: the test always runs to completion; only the first mismatch is recorded.

Test Plan:
- Adr_size=3, ideal RAM model, start pulse -> done after 87 edges, fail=0, exactly 40 mem_we and 40 mem_re pulses, busy low in DONE.
- Adr_size=3, RAM bit0 of addr 5 stuck-at-1 -> fail=1, fail_adr=5, fail_elem=1 (first r0 in M1); without BIST_FAIL_STOP_EN done still at edge 87.
- Same fault with BIST_FAIL_STOP_EN -> DONE entered one edge after detection, no strobes thereafter, done well before edge 87.
- Direction check: during M3/M4 gen_up=0 and gen_preset pulses once at element entry, so adr_in sequence is 7,6,...,0. No gen_en at address 0 (no wrap).
- rst_n pulled low mid-M2 -> all outputs 0 asynchronously; after release, a new start runs a full clean pass and reaches done at 87.
- start pulses while busy are ignored; a second start in DONE clears fail/done and reruns the test.
